sdram_arbiter: RTL

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// Slot-based two-port (CPU / video) arbiter in front of an SDRAM controller; clkref rising edges frame 8-clock slots.
// Optional forced refresh slot every 64th slot when SDRAM_ARB_FORCE_REFRESH_EN is defined.
module sdram_arbiter #(
  parameter logic [2:0] DATA_PHASE = 3'd6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkref,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ready,
  output logic        cpu_busy,
  input  logic [24:0] vid_addr,
  input  logic        vid_rd,
  output logic [7:0]  vid_dout,
  output logic        vid_ready,
  output logic [24:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_oe,
  output logic        ram_we,
  input  logic [7:0]  ram_dout
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_VID
  } owner_e;

  logic        clkref_q;
  logic        synced_q, synced_d;
  logic [2:0]  phase_q, phase_d;
  owner_e      owner_q, owner_d;
  logic        cpu_pend_q, cpu_pend_d;
  logic        cpu_wr_pend_q, cpu_wr_pend_d;
  logic        vid_pend_q, vid_pend_d;
  logic        cpu_waited_q, cpu_waited_d;
  logic [24:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_din_q, ram_din_d;
  logic        ram_oe_q, ram_oe_d;
  logic        ram_we_q, ram_we_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;
  logic [7:0]  vid_dout_q, vid_dout_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic        vid_ready_q, vid_ready_d;

  logic clkref_edge;
  logic early_edge;
  logic slot_start;
  logic forced_idle;
  logic capture;
  logic vid_busy;
  logic cpu_strobe;
  logic vid_strobe;
  logic grant_cpu;
  logic grant_vid;

  assign clkref_edge = clkref & ~clkref_q;
  assign early_edge  = clkref_edge & (phase_q != 3'd7);
  // Free-running wrap only counts as a slot boundary once clkref has framed the first slot.
  assign slot_start  = clkref_edge | (synced_q & (phase_q == 3'd7));
  assign capture     = (phase_q == DATA_PHASE) & ~early_edge;

  assign cpu_strobe  = (cpu_rd | cpu_wr) & ~cpu_busy;
  assign vid_strobe  = vid_rd & ~vid_busy;
  assign grant_cpu   = slot_start & ~forced_idle & cpu_pend_q & (~vid_pend_q | cpu_waited_q);
  assign grant_vid   = slot_start & ~forced_idle & vid_pend_q & ~grant_cpu;

`ifdef SDRAM_ARB_FORCE_REFRESH_EN
  logic [5:0] slot_cnt_q, slot_cnt_d;

  assign forced_idle = (slot_cnt_q == 6'd63);

  always_comb begin
    slot_cnt_d = slot_start ? slot_cnt_q + 6'd1 : slot_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt_q <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
    end
  end
`else
  assign forced_idle = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clkref_q      <= 1'b0;
      synced_q      <= 1'b0;
      phase_q       <= '0;
      owner_q       <= OWN_NONE;
      cpu_pend_q    <= 1'b0;
      cpu_wr_pend_q <= 1'b0;
      vid_pend_q    <= 1'b0;
      cpu_waited_q  <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_oe_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      cpu_dout_q    <= '0;
      vid_dout_q    <= '0;
      cpu_ready_q   <= 1'b0;
      vid_ready_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of every other.
      clkref_q      <= clkref;
      synced_q      <= synced_d;
      phase_q       <= phase_d;
      owner_q       <= owner_d;
      cpu_pend_q    <= cpu_pend_d;
      cpu_wr_pend_q <= cpu_wr_pend_d;
      vid_pend_q    <= vid_pend_d;
      cpu_waited_q  <= cpu_waited_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      ram_oe_q      <= ram_oe_d;
      ram_we_q      <= ram_we_d;
      cpu_dout_q    <= cpu_dout_d;
      vid_dout_q    <= vid_dout_d;
      cpu_ready_q   <= cpu_ready_d;
      vid_ready_q   <= vid_ready_d;
    end
  end

  // Next-state logic: phase, arbitration, pending flags, data capture.
  always_comb begin
    // NOTE: every target gets a default first, so no branch can leave one unassigned and infer a latch.
    phase_d       = clkref_edge ? 3'd0 : phase_q + 3'd1;
    synced_d      = synced_q | clkref_edge;
    owner_d       = owner_q;
    cpu_pend_d    = cpu_pend_q;
    cpu_wr_pend_d = cpu_wr_pend_q;
    vid_pend_d    = vid_pend_q;
    cpu_waited_d  = cpu_waited_q;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;
    ram_oe_d      = ram_oe_q;
    ram_we_d      = ram_we_q;
    cpu_dout_d    = cpu_dout_q;
    vid_dout_d    = vid_dout_q;
    cpu_ready_d   = 1'b0;
    vid_ready_d   = 1'b0;

    if (grant_cpu) begin
      cpu_pend_d = 1'b0;
    end else if (cpu_strobe) begin
      cpu_pend_d    = 1'b1;
      cpu_wr_pend_d = cpu_wr;
    end

    if (grant_vid) begin
      vid_pend_d = 1'b0;
    end else if (vid_strobe) begin
      vid_pend_d = 1'b1;
    end

    if (grant_cpu) begin
      cpu_waited_d = 1'b0;
    end else if (grant_vid & cpu_pend_q) begin
      cpu_waited_d = 1'b1;
    end

    // A new slot always replaces the current owner, which also aborts an access cut short by an early clkref.
    if (slot_start) begin
      ram_oe_d = grant_vid | (grant_cpu & ~cpu_wr_pend_q);
      ram_we_d = grant_cpu & cpu_wr_pend_q;
      if (grant_cpu) begin
        owner_d    = OWN_CPU;
        ram_addr_d = cpu_addr;
        ram_din_d  = cpu_din;
      end else if (grant_vid) begin
        owner_d    = OWN_VID;
        ram_addr_d = vid_addr;
      end else begin
        owner_d = OWN_NONE;
      end
    end

    if (capture && owner_q == OWN_CPU) begin
      cpu_ready_d = 1'b1;
      if (!ram_we_q) begin
        cpu_dout_d = ram_dout;
      end
    end
    if (capture && owner_q == OWN_VID) begin
      vid_ready_d = 1'b1;
      vid_dout_d  = ram_dout;
    end
  end

  // Output logic.
  always_comb begin
    cpu_busy = cpu_pend_q | (owner_q == OWN_CPU);
    vid_busy = vid_pend_q | (owner_q == OWN_VID);
  end

  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_oe    = ram_oe_q;
  assign ram_we    = ram_we_q;
  assign cpu_dout  = cpu_dout_q;
  assign vid_dout  = vid_dout_q;
  assign cpu_ready = cpu_ready_q;
  assign vid_ready = vid_ready_q;

endmodule
